cache_bus_bridge: RTL and testbench

Responder end of the cache-side memory interface that the MEM-stage dcache/uncache select logic drives (rd_req/rd_type/rd_addr, wr_req/wr_type/wr_addr/wr_wstrb).
Accepts one read or one write request at a time and serialises it into single-word transactions on the SRAM-like system bus (req / addr_ok / data_ok).
Returns read words to the cache one per cycle, in order.

---
 rtl/cache_bus_bridge_pkg.sv | 31 +++
 rtl/cache_bus_bridge.sv | 157 +++++++++++++++
 tb/tb_cache_bus_bridge.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_bus_bridge_pkg.sv
// Shared definitions for the cache-to-SRAM-bus bridge: request type codes,
// bus size codes and the bridge state encoding.
package cache_bus_bridge_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_e;

  // Unknown request codes fall back to a full-word access.
  function automatic logic [1:0] type_to_size(input logic [2:0] t);
    case (t)
      TYPE_BYTE: type_to_size = SIZE_BYTE;
      TYPE_HALF: type_to_size = SIZE_HALF;
      default:   type_to_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/cache_bus_bridge.sv
// Serialises one cache read or write request (single access or whole line)
// into single-word transactions on the SRAM-like bus; read words return in order.
module cache_bus_bridge
  import cache_bus_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     bus_req,
  output logic                     bus_wr,
  output logic [1:0]               bus_size,
  output logic [31:0]              bus_addr,
  output logic [3:0]               bus_wstrb,
  output logic [31:0]              bus_wdata,
  input  logic                     bus_addr_ok,
  input  logic                     bus_data_ok,
  input  logic [31:0]              bus_rdata
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam int DW = 32 * LINE_WORDS;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      type_q, type_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ret_valid_q, ret_valid_d;
  logic            ret_last_q, ret_last_d;
  logic [31:0]     ret_data_q, ret_data_d;

  logic            is_line;
  logic            is_rd;
  logic            last_word;
  logic            word_done;

  assign is_line   = (type_q == TYPE_LINE);
  assign is_rd     = (state_q == RD_REQ) || (state_q == RD_WAIT);
  assign last_word = !is_line || (cnt_q == CW'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
    end
  end

  // Writes win a same-cycle contest so a dirty writeback precedes its refill.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    ret_valid_d = 1'b0;
    ret_last_d  = 1'b0;
    ret_data_d  = ret_data_q;
    word_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_req) begin
          type_d  = wr_type;
          addr_d  = wr_addr;
          wstrb_d = wr_wstrb;
          wdata_d = wr_data;
          cnt_d   = '0;
          state_d = WR_REQ;
        end else if (rd_req) begin
          type_d  = rd_type;
          addr_d  = rd_addr;
          wstrb_d = '0;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            word_done = 1'b1;
          end else begin
            state_d = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (bus_data_ok) begin
          word_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (last_word) begin
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = is_rd ? RD_REQ : WR_REQ;
      end
      if (is_rd) begin
        ret_valid_d = 1'b1;
        ret_last_d  = last_word;
        ret_data_d  = bus_rdata;
      end
    end
  end

  assign rd_rdy    = (state_q == IDLE) && !wr_req;
  assign wr_rdy    = (state_q == IDLE);
  assign bus_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign bus_wr    = (state_q == WR_REQ) || (state_q == WR_WAIT);
  assign bus_size  = is_line ? SIZE_WORD : type_to_size(type_q);
  assign bus_addr  = is_line ? {addr_q[31:CW+2], cnt_q, 2'b00} : addr_q;
  assign bus_wstrb = !bus_wr ? 4'b0000 : (is_line ? 4'b1111 : wstrb_q);
  // Non-line accesses keep cnt at zero, so they naturally select word 0.
  assign bus_wdata = wdata_q[{cnt_q, 5'b00000} +: 32];

  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;

endmodule

// File: tb/tb_cache_bus_bridge.sv
// Directed and randomized bench for cache_bus_bridge; expected bus traffic and
// read returns are derived from the request itself, not from the DUT's state.
module tb_cache_bus_bridge;
  import cache_bus_bridge_pkg::*;

  localparam int LW = 4;

  logic            clk;
  logic            resetn;
  logic            rd_req;
  logic [2:0]      rd_type;
  logic [31:0]     rd_addr;
  logic            rd_rdy;
  logic            ret_valid;
  logic            ret_last;
  logic [31:0]     ret_data;
  logic            wr_req;
  logic [2:0]      wr_type;
  logic [31:0]     wr_addr;
  logic [3:0]      wr_wstrb;
  logic [32*LW-1:0] wr_data;
  logic            wr_rdy;
  logic            bus_req;
  logic            bus_wr;
  logic [1:0]      bus_size;
  logic [31:0]     bus_addr;
  logic [3:0]      bus_wstrb;
  logic [31:0]     bus_wdata;
  logic            bus_addr_ok;
  logic            bus_data_ok;
  logic [31:0]     bus_rdata;

  int checks   = 0;
  int failures = 0;

  cache_bus_bridge #(.LINE_WORDS(LW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rd_req      (rd_req),
    .rd_type     (rd_type),
    .rd_addr     (rd_addr),
    .rd_rdy      (rd_rdy),
    .ret_valid   (ret_valid),
    .ret_last    (ret_last),
    .ret_data    (ret_data),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays both the cache side and the bus responder for one request.
  task automatic doReq(input bit isWr, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [3:0] strb, input int aDly, input int dDly, input bit same);
    logic [32*LW-1:0] data;
    logic [31:0]      base, expAddr, rdata, expWdata;
    logic [3:0]       expStrb;
    logic [1:0]       expSize;
    int               n;
    for (int w = 0; w < LW; w++) data[32*w +: 32] = $urandom;
    n       = (typ == TYPE_LINE) ? LW : 1;
    base    = addr - (addr % (LW * 4));
    expSize = (typ == TYPE_BYTE) ? 2'd0 : (typ == TYPE_HALF) ? 2'd1 : 2'd2;

    if (isWr) begin
      wr_req = 1'b1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
    end else begin
      rd_req = 1'b1; rd_type = typ; rd_addr = addr;
    end
    #1;
    if (isWr) begin
      check("accept_wr_rdy", 32'(wr_rdy), 32'd1);
      check("accept_rd_rdy_blocked", 32'(rd_rdy), 32'd0);
    end else begin
      check("accept_rd_rdy", 32'(rd_rdy), 32'd1);
    end
    tick();
    if (isWr) begin
      wr_req = 1'b0; wr_addr = $urandom; wr_data = {LW{$urandom}}; wr_wstrb = 4'($urandom);
    end else begin
      rd_req = 1'b0; rd_addr = $urandom;
    end

    for (int i = 0; i < n; i++) begin
      expAddr  = (n > 1) ? base + 32'(4 * i) : addr;
      expStrb  = !isWr ? 4'b0000 : (n > 1) ? 4'b1111 : strb;
      expWdata = data[32*i +: 32];
      rdata    = $urandom;
      for (int k = 0; k <= aDly; k++) begin
        check("bus_req", 32'(bus_req), 32'd1);
        check("bus_wr", 32'(bus_wr), 32'(isWr));
        check("bus_size", 32'(bus_size), 32'(expSize));
        check("bus_addr", bus_addr, expAddr);
        check("bus_wstrb", 32'(bus_wstrb), 32'(expStrb));
        if (isWr) check("bus_wdata", bus_wdata, expWdata);
        check("busy_rd_rdy", 32'(rd_rdy), 32'd0);
        if (k < aDly) tick();
      end
      bus_addr_ok = 1'b1;
      if (same) begin
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
      end
      tick();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (!same) begin
        for (int d = 0; d < dDly; d++) begin
          check("wait_bus_req", 32'(bus_req), 32'd0);
          check("wait_ret_valid", 32'(ret_valid), 32'd0);
          tick();
        end
        check("wait_bus_req", 32'(bus_req), 32'd0);
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
      end
      if (isWr) begin
        check("wr_ret_valid", 32'(ret_valid), 32'd0);
      end else begin
        check("ret_valid", 32'(ret_valid), 32'd1);
        check("ret_data", ret_data, rdata);
        check("ret_last", 32'(ret_last), 32'(i == n - 1));
      end
    end
    check("done_wr_rdy", 32'(wr_rdy), 32'd1);
    check("done_bus_req", 32'(bus_req), 32'd0);
  endtask

  initial begin
    logic [2:0] typeList [6];
    logic [31:0] savedData;
    typeList = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b100};

    resetn = 1'b0; rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    repeat (3) tick();
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_ret_valid", 32'(ret_valid), 32'd0);
    check("rst_ret_last", 32'(ret_last), 32'd0);
    check("rst_ret_data", ret_data, 32'd0);
    check("rst_rd_rdy", 32'(rd_rdy), 32'd1);
    check("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    resetn = 1'b1;
    tick();

    $display("[TB] line read with delayed data_ok");
    doReq(1'b0, TYPE_LINE, 32'h1FC0_0014, 4'h0, 0, 2, 1'b0);
    tick();
    check("idle_ret_valid", 32'(ret_valid), 32'd0);
    check("idle_ret_last", 32'(ret_last), 32'd0);

    $display("[TB] byte write");
    doReq(1'b1, TYPE_BYTE, 32'h1FAF_0003, 4'b1000, 0, 1, 1'b0);

    $display("[TB] simultaneous write and read");
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_1234;
    doReq(1'b1, TYPE_LINE, 32'h0000_8008, 4'h0, 1, 0, 1'b0);
    doReq(1'b0, TYPE_LINE, 32'h0000_1234, 4'h0, 0, 0, 1'b0);

    $display("[TB] line read with addr_ok and data_ok together");
    doReq(1'b0, TYPE_LINE, 32'hABCD_EF7C, 4'h0, 0, 0, 1'b1);

    $display("[TB] addr_ok held off for five cycles");
    doReq(1'b0, TYPE_WORD, 32'h2000_0040, 4'h0, 5, 1, 1'b0);

    $display("[TB] reset in the middle of a line read");
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h3000_0020;
    #1;
    tick();
    rd_req = 1'b0;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_0001;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    check("mid_ret_data", ret_data, 32'hCAFE_0001);
    check("mid_bus_addr", bus_addr, 32'h3000_0024);
    check("mid_bus_req", 32'(bus_req), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_bus_req", 32'(bus_req), 32'd0);
    check("async_ret_data", ret_data, 32'd0);
    #2;
    resetn = 1'b1;
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_data_ok = 1'b0;
    check("stray_ret_valid", 32'(ret_valid), 32'd0);
    check("stray_bus_req", 32'(bus_req), 32'd0);
    check("stray_rd_rdy", 32'(rd_rdy), 32'd1);
    check("stray_ret_data", ret_data, 32'd0);
    tick();

    $display("[TB] randomized requests");
    for (int r = 0; r < 24; r++) begin
      doReq(1'($urandom_range(0, 1)), typeList[$urandom_range(0, 5)], $urandom,
            4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)));
      savedData = ret_data;
      tick();
      check("gap_ret_valid", 32'(ret_valid), 32'd0);
      check("gap_ret_hold", ret_data, savedData);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
